frame_buffer_wr_ctrl: RTL
=========================

// Module: frame_buffer_wr_ctrl
// PURPOSE
//  Write-side scheduler for the camera frame buffer. Pops 16-bit RGB565 pixels from the
//  DVP RX FIFO (read side, clk_i domain) and writes them to the BRAM frame store at
//  linear addresses. Frames are delimited by SOF/EOF pulses from the DVP RX. Flags short,
//  long and oversize frames. Publishes the base address of the last complete frame to HDMI read side.
// PARAMETERS
//  DATA_WIDTH_FIFO    16    FIFO read-data width (one pixel)
//  BRAM_ADDR_WIDTH    32    BRAM address width
//  BRAM_DATA_WIDTH    16    BRAM write-data width; equals DATA_WIDTH_FIFO
//  BRAM_NUMBER_BLOCK  75    number of BRAM blocks
//  BRAM_DEPTH_SIZE    4096  words per block; CAPACITY = BLOCK*DEPTH (307200)
// PORTS
//  clk_i               in   1    system clock; the only clock
//  resetn_i            in   1    synchronous, active-low reset
//  enable_i            in   1    0 forces IDLE at the next edge
//  resolution_width_i  in   16   pixels per line
//  resolution_depth_i  in   16   lines per frame
//  frame_start_i       in   1    1-cycle SOF pulse (VSYNC fall, already synchronised)
//  frame_end_i         in   1    1-cycle EOF pulse (VSYNC rise, already synchronised)
//  fifo_empty_i        in   1    FIFO empty
//  fifo_rd_data_i      in   16   FIFO head word (first-word-fall-through)
//  fifo_rd_en_o        out  1    pop; asserted only when fifo_empty_i=0
//  bram_we_o           out  1    BRAM write strobe
//  bram_addr_o         out  32   BRAM word address
//  bram_wdata_o        out  16   BRAM write data
//  frame_done_o        out  1    1-cycle pulse: full frame written
//  frame_error_o       out  1    1-cycle pulse: short/long/bad-config frame
//  busy_o              out  1    1 while in CAPTURE
//  rd_base_o           out  32   base address of last complete frame
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pix_cnt 0, wr_base 0.
//  FSM IDLE -> WAIT_SOF when enable_i=1. Any state -> IDLE when enable_i=0; no pulse.
//  WAIT_SOF: pops and discards while FIFO not empty. No BRAM write. On frame_start_i:
//   latch total = width*depth (32-bit). If total = 0 or total > REGION: frame_error_o
//   pulses and state stays WAIT_SOF. Otherwise pix_cnt <= 0 and state -> CAPTURE.
//  CAPTURE: fifo_rd_en_o = !fifo_empty_i && pix_cnt < total.
//   Pop at edge n: at n+1, bram_we_o=1, bram_wdata_o=popped word, bram_addr_o=wr_base+pix_cnt.
//   Write latency is 1 cycle; sustained rate is 1 pixel/clk; pix_cnt++ per pop.
//  Completion: pop that makes pix_cnt = total -> DONE for 1 cycle.
//   In DONE: frame_done_o=1, rd_base_o <= wr_base. Then -> WAIT_SOF.
//  Short frame: frame_end_i or frame_start_i in CAPTURE with pix_cnt < total ->
//   frame_error_o pulse and rd_base_o unchanged.
//   frame_start_i restarts CAPTURE (pix_cnt <= 0, re-latch total); frame_end_i -> WAIT_SOF.
//  Pop on same edge as SOF/EOF is counted before the event is evaluated.
//  Long frame: extra pixels are popped and discarded in WAIT_SOF with no error.
//  frame_error_o pulses once per offending frame.
//  Config is sampled only at SOF; mid-frame changes are ignored.
//  Reset mid-frame: in-flight write is dropped (bram_we_o=0 next cycle).
// CONFIGURATION
//  FBC_DOUBLE_BUFFER_EN defined:
//   REGION = CAPACITY/2; wr_base toggles 0 <-> REGION after each DONE.
//   rd_base_o never equals the active wr_base.
//  Not defined: REGION = CAPACITY; wr_base fixed at 0; rd_base_o stays 0.
// STRUCTURE
//  Package frame_buffer_pkg: FSM state enum (IDLE, WAIT_SOF, CAPTURE, DONE),
//   CAPACITY/REGION localparams, pixel word width constant.
//  Sub-module fb_addr_gen: pix_cnt, total compare, wr_base toggle, bram_addr_o register.
//  The FSM stays in this module.
// TESTING
//  1. 4x2 frame, 8 words queued, SOF -> 8 writes at addr 0..7, data in order,
//     then frame_done_o pulse; rd_base_o=0.
//  2. FIFO empty every other cycle during a 4x2 frame -> no write while empty;
//     addresses contiguous; done after 8th write.
//  3. 4x2 frame, EOF after 5 pixels -> frame_error_o=1 once, no done, next SOF writes from addr 0.
//  4. 10 words queued for a 4x2 frame -> 8 writes; remaining 2 popped with bram_we_o=0; no error.
//  5. width=0 or 640x481 (exceeds REGION) -> error pulse at SOF, no writes, stays WAIT_SOF.
//  6. FBC_DOUBLE_BUFFER_EN, two 4x2 frames -> frame1 at 0..7, frame2 at 153600..153607;
//     rd_base_o 0 then 153600. Reset asserted mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared types and constants for the frame buffer write controller.
// Define FBC_DOUBLE_BUFFER_EN to split the store into two ping-pong regions.
package frame_buffer_pkg;

    localparam int PIX_W    = 16;
    localparam int CAPACITY = 75 * 4096;

`ifdef FBC_DOUBLE_BUFFER_EN
    localparam bit DOUBLE_BUF = 1'b1;
    localparam int REGION     = CAPACITY / 2;
`else
    localparam bit DOUBLE_BUF = 1'b0;
    localparam int REGION     = CAPACITY;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } fbc_state_t;

endpackage

// File: rtl/frame_buffer_wr_ctrl_addr_gen.sv
// Pixel counter, frame-size compare, write-base ping-pong and BRAM address register.
// The base toggles only when the package enables double buffering (FBC_DOUBLE_BUFFER_EN).
module fb_addr_gen
    import frame_buffer_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] REGION_WORDS = 32'(REGION)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [31:0]       total_new,
    input  logic              pop,
    input  logic              advance,
    output logic              below,
    output logic              last_pop,
    output logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] addr
);

    logic [31:0] pix_cnt;
    logic [31:0] total;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_cnt <= '0;
            total   <= '0;
            wr_base <= '0;
            addr    <= '0;
        end else begin
            // A restart wins over the pop on the same edge; that pop is still written.
            if (load) begin
                pix_cnt <= '0;
                total   <= total_new;
            end else if (pop) begin
                pix_cnt <= pix_cnt + 32'd1;
            end
            if (pop) begin
                addr <= wr_base + ADDR_W'(pix_cnt);
            end
            if (advance && DOUBLE_BUF) begin
                wr_base <= (wr_base == '0) ? ADDR_W'(REGION_WORDS) : '0;
            end
        end
    end

    assign below    = (pix_cnt < total);
    assign last_pop = pop && ((pix_cnt + 32'd1) == total);

endmodule

// File: rtl/frame_buffer_wr_ctrl.sv
// Camera frame buffer write scheduler: FIFO pixels -> linear BRAM addresses, per SOF/EOF frame.
// With FBC_DOUBLE_BUFFER_EN the completed frame's region is published while the other is filled.
module frame_buffer_wr_ctrl
    import frame_buffer_pkg::*;
#(
    parameter int DATA_WIDTH_FIFO   = 16,
    parameter int BRAM_ADDR_WIDTH   = 32,
    parameter int BRAM_DATA_WIDTH   = 16,
    parameter int BRAM_NUMBER_BLOCK = 75,
    parameter int BRAM_DEPTH_SIZE   = 4096
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       enable_i,
    input  logic [15:0]                resolution_width_i,
    input  logic [15:0]                resolution_depth_i,
    input  logic                       frame_start_i,
    input  logic                       frame_end_i,
    input  logic                       fifo_empty_i,
    input  logic [DATA_WIDTH_FIFO-1:0] fifo_rd_data_i,
    output logic                       fifo_rd_en_o,
    output logic                       bram_we_o,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic [BRAM_DATA_WIDTH-1:0] bram_wdata_o,
    output logic                       frame_done_o,
    output logic                       frame_error_o,
    output logic                       busy_o,
    output logic [BRAM_ADDR_WIDTH-1:0] rd_base_o,
    output fbc_state_t                 state_o
);

    localparam logic [31:0] CAP_WORDS    = 32'(BRAM_NUMBER_BLOCK * BRAM_DEPTH_SIZE);
    localparam logic [31:0] REGION_WORDS = DOUBLE_BUF ? (CAP_WORDS / 32'd2) : CAP_WORDS;

    fbc_state_t                 state, state_next;
    logic                       rd_en, cap_pop, load, err_set, advance;
    logic                       below, last_pop;
    logic [31:0]                total_now;
    logic                       cfg_ok;
    logic [BRAM_ADDR_WIDTH-1:0] wr_base;

    assign total_now = 32'(resolution_width_i) * 32'(resolution_depth_i);
    assign cfg_ok    = (total_now != 32'd0) && (total_now <= REGION_WORDS);

    fb_addr_gen #(
        .ADDR_W       (BRAM_ADDR_WIDTH),
        .REGION_WORDS (REGION_WORDS)
    ) u_addr_gen (
        .clk       (clk_i),
        .resetn    (resetn_i),
        .load      (load),
        .total_new (total_now),
        .pop       (cap_pop),
        .advance   (advance),
        .below     (below),
        .last_pop  (last_pop),
        .wr_base   (wr_base),
        .addr      (bram_addr_o)
    );

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        cap_pop    = 1'b0;
        load       = 1'b0;
        err_set    = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                // Leftover pixels from a long frame are drained here without writing.
                rd_en = !fifo_empty_i;
                if (frame_start_i) begin
                    if (cfg_ok) begin
                        load       = 1'b1;
                        state_next = CAPTURE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                rd_en   = !fifo_empty_i && below;
                cap_pop = rd_en;
                // The pop on this edge counts first, so a completing pop beats SOF/EOF.
                if (cap_pop && last_pop) begin
                    state_next = DONE;
                end else if (frame_start_i) begin
                    err_set = 1'b1;
                    if (cfg_ok) begin
                        load = 1'b1;
                    end else begin
                        state_next = WAIT_SOF;
                    end
                end else if (frame_end_i) begin
                    err_set    = 1'b1;
                    state_next = WAIT_SOF;
                end
            end
            DONE: begin
                advance    = 1'b1;
                state_next = WAIT_SOF;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable_i || !resetn_i) begin
            state_next = IDLE;
            rd_en      = 1'b0;
            cap_pop    = 1'b0;
            load       = 1'b0;
            err_set    = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            bram_we_o     <= 1'b0;
            bram_wdata_o  <= '0;
            frame_error_o <= 1'b0;
            rd_base_o     <= '0;
        end else begin
            bram_we_o     <= cap_pop;
            frame_error_o <= err_set;
            if (cap_pop) begin
                bram_wdata_o <= fifo_rd_data_i;
            end
            if (advance) begin
                rd_base_o <= wr_base;
            end
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign frame_done_o = (state == DONE);
    assign busy_o       = (state == CAPTURE);
    assign state_o      = state;

endmodule
